tx_byte_sequencer: RTL and testbench

Transmit-side controller that sequences the byte shift register (mux-select + parallel-to-serial) to send one packet. It sends a SYNC byte, then a PID byte, then `data_len` payload bytes popped from the transmit FIFO, then an EOP interval. It generates the register's `load_en`, `shift_enable`, `select` and `fsm_byte` at the configured bit rate, and reports completion or FIFO underrun to the packet-level FSM.

---
 rtl/tx_byte_sequencer.sv | 110 +++++++++++
 tb/tb_tx_byte_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tx_byte_sequencer.sv
// tx_byte_sequencer: paces SYNC, PID, payload and EOP through the byte shift register for one packet
module tx_byte_sequencer #(
    parameter int         CLKS_PER_BIT = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pid,
    input  logic [6:0] data_len,
    input  logic       fifo_empty,
    output logic       load_en,
    output logic       shift_enable,
    output logic       select,
    output logic [7:0] fsm_byte,
    output logic       fifo_read,
    output logic       tx_active,
    output logic       eop,
    output logic       done,
    output logic       error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE = 3'd0, SYNC = 3'd1, PID = 3'd2, DATA = 3'd3, EOP = 3'd4, DONE = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cyc;
    logic [2:0]    bit_idx;
    logic [6:0]    rem;
    logic [7:0]    pid_q;
    logic          active, sending, tick, slot_end;

    assign active   = state inside {SYNC, PID, DATA, EOP};
    assign sending  = state inside {SYNC, PID, DATA};
    assign tick     = cyc == CMAX;
    assign slot_end = tick && bit_idx == 3'd7;

    // Bit-period timebase; both counters wrap to zero at a slot end, so every new slot or EOP starts aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc     <= '0;
            bit_idx <= 3'd0;
        end else begin
            cyc     <= (!active || tick) ? '0 : cyc + 1'b1;
            bit_idx <= active ? bit_idx + {2'b00, tick} : 3'd0;
        end
    end

    // Packet FSM; strobes default low so load/shift/read/done are single-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= 7'd0;
            pid_q        <= 8'h00;
            load_en      <= 1'b0;
            shift_enable <= 1'b0;
            select       <= 1'b0;
            fsm_byte     <= 8'h00;
            fifo_read    <= 1'b0;
            tx_active    <= 1'b0;
            eop          <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            load_en      <= 1'b0;
            fifo_read    <= 1'b0;
            done         <= 1'b0;
            shift_enable <= sending && tick && bit_idx != 3'd7;
            case (state)
                IDLE: if (start) begin
                    state     <= SYNC;
                    pid_q     <= pid;
                    rem       <= data_len;
                    error     <= 1'b0;
                    load_en   <= 1'b1;
                    select    <= 1'b1;
                    fsm_byte  <= SYNC_BYTE;
                    tx_active <= 1'b1;
                end
                SYNC: if (slot_end) begin
                    state    <= PID;
                    load_en  <= 1'b1;
                    select   <= 1'b1;
                    fsm_byte <= pid_q;
                end
                PID, DATA: if (slot_end) begin
                    if (rem != 7'd0 && !fifo_empty) begin
                        state     <= DATA;
                        load_en   <= 1'b1;
                        select    <= 1'b0;
                        fifo_read <= 1'b1;
                        rem       <= rem - 7'd1;
                    end else begin
                        state <= EOP;
                        eop   <= 1'b1;
                        if (rem != 7'd0) error <= 1'b1;
                    end
                end
                EOP: if (tick && bit_idx == 3'd1) begin
                    state     <= DONE;
                    eop       <= 1'b0;
                    tx_active <= 1'b0;
                    done      <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_byte_sequencer.sv
// tb_tx_byte_sequencer: directed and random packets checked cycle by cycle against a slot-arithmetic model
module tb_tx_byte_sequencer;
    localparam int C = 4;
    localparam int SLOT = 8 * C;
    localparam logic [7:0] SB = 8'h80;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] pid = 8'h00;
    logic [6:0] data_len = 7'd0;
    logic       fifo_empty;
    logic       load_en, shift_enable, select, fifo_read, tx_active, eop, done, error;
    logic [7:0] fsm_byte;

    int total = 0, bad = 0;
    int pushed = 0, pops = 0;

    tx_byte_sequencer #(.CLKS_PER_BIT(C), .SYNC_BYTE(SB)) dut (
        .clk(clk), .rst(rst), .start(start), .pid(pid), .data_len(data_len),
        .fifo_empty(fifo_empty), .load_en(load_en), .shift_enable(shift_enable),
        .select(select), .fsm_byte(fsm_byte), .fifo_read(fifo_read),
        .tx_active(tx_active), .eop(eop), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // FIFO is modelled by a level: bytes pushed by the stimulus minus bytes popped by the DUT
    assign fifo_empty = (pushed == pops);

    // Inputs as seen at each rising edge, plus the FIFO pop bookkeeping
    logic       s_rst = 1'b1, s_start = 1'b0;
    logic [7:0] s_pid = 8'h00;
    int         s_len = 0, s_avail = 0;
    always @(posedge clk) begin
        s_rst   <= rst;
        s_start <= start;
        s_pid   <= pid;
        s_len   <= int'(data_len);
        s_avail <= pushed - pops;
        if (fifo_read) pops <= pops + 1;
    end

    // Reference model: a packet is (2+nb) slots of SLOT cycles then 2*C EOP cycles, done one cycle later
    bit         m_busy = 1'b0;
    int         d = 0, m_len = 0, nb = 0, e_cyc = 0, slot = 0, j = 0;
    logic [7:0] m_pid = 8'h00, h_fsm = 8'h00;
    logic       h_sel = 1'b0, h_err = 1'b0;
    logic       le, se, fr, ta, ep, dn;
    logic [7:0] exp_v;
    always @(negedge clk) begin
        if (s_rst) begin
            m_busy = 1'b0; d = 0; h_sel = 1'b0; h_fsm = 8'h00; h_err = 1'b0;
        end else if (m_busy) begin
            if (d == e_cyc + 2 * C) m_busy = 1'b0;
            else d++;
        end else if (s_start) begin
            m_busy = 1'b1; d = 1; m_len = s_len; m_pid = s_pid; h_err = 1'b0;
            nb = (s_len < s_avail) ? s_len : s_avail;
            e_cyc = 1 + SLOT * (2 + nb);
        end
        {le, se, fr, ta, ep, dn} = 6'b0;
        if (m_busy) begin
            if (d < e_cyc) begin
                slot = (d - 1) / SLOT;
                j = (d - 1) % SLOT;
                le = (j == 0);
                se = (j != 0) && (j % C == 0);
                fr = le && slot >= 2;
                if (le) begin
                    h_sel = (slot < 2);
                    if (slot == 0) h_fsm = SB;
                    else if (slot == 1) h_fsm = m_pid;
                end
            end
            ta = d < e_cyc + 2 * C;
            ep = d >= e_cyc && ta;
            dn = d == e_cyc + 2 * C;
            if (d >= e_cyc && m_len > nb) h_err = 1'b1;
        end
        exp_v = {le, se, h_sel, fr, ta, ep, dn, h_err};
        total++;
        assert ({load_en, shift_enable, select, fifo_read, tx_active, eop, done, error} === exp_v)
        else begin
            bad++;
            $error("FAIL ctl d=%0d got=%b exp=%b (load,shift,sel,read,act,eop,done,err)",
                   d, {load_en, shift_enable, select, fifo_read, tx_active, eop, done, error}, exp_v);
        end
        total++;
        assert (fsm_byte === h_fsm)
        else begin
            bad++;
            $error("FAIL fsm_byte d=%0d got=%h exp=%h", d, fsm_byte, h_fsm);
        end
    end

    // Send one packet and measure start-to-done latency; extra>0 keeps start high that many extra cycles
    task automatic send(input logic [7:0] p, input int len, input int nf, input int pulse_at, input int extra);
        int n = 0;
        int nbb = (len < nf) ? len : nf;
        int exp_n = 1 + SLOT * (2 + nbb) + 2 * C + extra;
        pushed = pops + nf;
        pid = p;
        data_len = 7'(len);
        start = 1'b1;
        do begin
            @(negedge clk);
            n++;
            start = (n <= extra) || (n == pulse_at);
        end while (!done && n < 4000);
        start = 1'b0;
        total++;
        assert (n == exp_n)
        else begin
            bad++;
            $error("FAIL done_time got=%0d exp=%0d", n, exp_n);
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        assert ({load_en, shift_enable, select, fifo_read, tx_active, eop, done, error, fsm_byte} === 16'h0)
        else begin
            bad++;
            $error("FAIL %s got=%b exp=0", tag,
                   {load_en, shift_enable, select, fifo_read, tx_active, eop, done, error, fsm_byte});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset_init");
        rst = 1'b0;
        @(negedge clk);
        send(8'hA5, 0, 0, 0, 0);
        @(negedge clk);
        send(8'h3C, 3, 3, 0, 0);
        send(8'h5A, 2, 2, 0, 1);
        @(negedge clk);
        send(8'hC3, 3, 1, 0, 0);
        repeat (5) @(negedge clk);
        send(8'h11, 4, 4, 100, 0);
        @(negedge clk);
        pushed = pops + 3;
        pid = 8'h99;
        data_len = 7'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (98) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h77, 2, 2, 0, 0);
        repeat (12) begin
            int len, nf;
            @(negedge clk);
            len = $urandom_range(0, 4);
            nf = $urandom_range(0, len + 1);
            send(8'($urandom), len, nf, 0, 0);
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
